// File: rtl/cms_ctrl_axil_bridge_if.sv
`default_nettype none
// ============================================================================
// cms_ctrl_axil_bridge_if : AXI4-Lite bus bundle for the CMS control bridge.
// Rev 1.0
// ============================================================================
interface cms_ctrl_axil_bridge_if #(
  parameter int AXIL_ADDR_WIDTH = 6
);
  logic [AXIL_ADDR_WIDTH-1:0] awaddr;
  logic                       awvalid;
  logic                       awready;
  logic [31:0]                wdata;
  logic [3:0]                 wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  logic [AXIL_ADDR_WIDTH-1:0] araddr;
  logic                       arvalid;
  logic                       arready;
  logic [31:0]                rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/cms_ctrl_axil_bridge.sv
`default_nettype none
// ============================================================================
// cms_ctrl_axil_bridge : AXI4-Lite slave staging 64-bit CMS control writes.
// Macro CMS_CTRL_ADDR_CHECK_EN rejects ADDR_GO above MAX_CTRL_ADDR.  Rev 1.0
// ============================================================================
module cms_ctrl_axil_bridge #(
  parameter int AXIL_ADDR_WIDTH = 6,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64,
  parameter int MAX_CTRL_ADDR   = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cms_ctrl_axil_bridge_if.slave      s_axi,
  output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       ctrl_write_enable
);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  localparam logic [0:0] c_w_idle = 1'b0;
  localparam logic [0:0] c_w_resp = 1'b1;
  localparam logic [0:0] c_r_idle = 1'b0;
  localparam logic [0:0] c_r_data = 1'b1;

  localparam logic [1:0] c_reg_data_lo = 2'd0;
  localparam logic [1:0] c_reg_data_hi = 2'd1;
  localparam logic [1:0] c_reg_addr_go = 2'd2;

  if (CTRL_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("CTRL_DATA_WIDTH must be 64 (two 32-bit halves)");
  end
  if (AXIL_ADDR_WIDTH < 5 || CTRL_ADDR_WIDTH > 32 ||
      MAX_CTRL_ADDR >= (1 << CTRL_ADDR_WIDTH)) begin : g_bad_addr_cfg
    $error("inconsistent address parameters");
  end

  logic [0:0]                 w_state_q, w_state_d;
  logic [0:0]                 r_state_q, r_state_d;
  logic [31:0]                data_lo_q, data_lo_d;
  logic [31:0]                data_hi_q, data_hi_d;
  logic [31:0]                issue_count_q, issue_count_d;
  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata_q, ctrl_wdata_d;
  logic                       strobe_q, strobe_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;

  logic       wr_fire;
  logic       rd_fire;
  logic       wr_unmapped;
  logic       rd_unmapped;
  logic [1:0] wr_reg;
  logic [1:0] rd_reg;
  logic       go_addr_ok;
  logic       unused_addr_lsbs;

  assign wr_reg           = s_axi.awaddr[3:2];
  assign rd_reg           = s_axi.araddr[3:2];
  assign wr_unmapped      = |s_axi.awaddr[AXIL_ADDR_WIDTH-1:4];
  assign rd_unmapped      = |s_axi.araddr[AXIL_ADDR_WIDTH-1:4];
  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Both channels are taken in the same cycle, and only from idle, so a
  // pending response always blocks the next write.
  assign wr_fire = (w_state_q == c_w_idle) && s_axi.awvalid && s_axi.wvalid;
  assign rd_fire = (r_state_q == c_r_idle) && s_axi.arvalid;

`ifdef CMS_CTRL_ADDR_CHECK_EN
  assign go_addr_ok = (32'(s_axi.wdata[CTRL_ADDR_WIDTH-1:0]) <= 32'(MAX_CTRL_ADDR));
`else
  assign go_addr_ok = 1'b1;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
    end
    return m;
  endfunction

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= c_w_idle;
      r_state_q <= c_r_idle;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      c_w_idle: if (wr_fire)      w_state_d = c_w_resp;
      default:  if (s_axi.bready) w_state_d = c_w_idle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      c_r_idle: if (rd_fire)      r_state_d = c_r_data;
      default:  if (s_axi.rready) r_state_d = c_r_idle;
    endcase
  end

  // Output logic
  always_comb begin
    s_axi.awready     = wr_fire;
    s_axi.wready      = wr_fire;
    s_axi.bvalid      = (w_state_q == c_w_resp);
    s_axi.bresp       = bresp_q;
    s_axi.arready     = rd_fire;
    s_axi.rvalid      = (r_state_q == c_r_data);
    s_axi.rdata       = rdata_q;
    s_axi.rresp       = rresp_q;
    ctrl_addr         = ctrl_addr_q;
    ctrl_wdata        = ctrl_wdata_q;
    ctrl_write_enable = strobe_q;
  end

  // Write datapath; the count advances after the strobe cycle so a read
  // landing on the strobe sees the pre-increment value.
  always_comb begin
    data_lo_d     = data_lo_q;
    data_hi_d     = data_hi_q;
    ctrl_addr_d   = ctrl_addr_q;
    ctrl_wdata_d  = ctrl_wdata_q;
    bresp_d       = bresp_q;
    strobe_d      = 1'b0;
    issue_count_d = issue_count_q + {31'd0, strobe_q};
    if (wr_fire) begin
      bresp_d = c_resp_okay;
      if (wr_unmapped) begin
        bresp_d = c_resp_slverr;
      end else begin
        case (wr_reg)
          c_reg_data_lo: data_lo_d = merge_bytes(data_lo_q, s_axi.wdata, s_axi.wstrb);
          c_reg_data_hi: data_hi_d = merge_bytes(data_hi_q, s_axi.wdata, s_axi.wstrb);
          c_reg_addr_go: begin
            if (s_axi.wstrb[0]) begin
              if (go_addr_ok) begin
                ctrl_addr_d  = s_axi.wdata[CTRL_ADDR_WIDTH-1:0];
                ctrl_wdata_d = {data_hi_q, data_lo_q};
                strobe_d     = 1'b1;
              end else begin
                bresp_d = c_resp_slverr;
              end
            end
          end
          default: bresp_d = c_resp_slverr;
        endcase
      end
    end
  end

  // Read datapath samples current register values, so a same-cycle write
  // is not visible to the read.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_fire) begin
      rdata_d = '0;
      rresp_d = c_resp_okay;
      if (rd_unmapped) begin
        rresp_d = c_resp_slverr;
      end else begin
        case (rd_reg)
          c_reg_data_lo: rdata_d = data_lo_q;
          c_reg_data_hi: rdata_d = data_hi_q;
          c_reg_addr_go: rdata_d = 32'(ctrl_addr_q);
          default:       rdata_d = issue_count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_lo_q     <= '0;
      data_hi_q     <= '0;
      issue_count_q <= '0;
      ctrl_addr_q   <= '0;
      ctrl_wdata_q  <= '0;
      strobe_q      <= 1'b0;
      bresp_q       <= c_resp_okay;
      rdata_q       <= '0;
      rresp_q       <= c_resp_okay;
    end else begin
      data_lo_q     <= data_lo_d;
      data_hi_q     <= data_hi_d;
      issue_count_q <= issue_count_d;
      ctrl_addr_q   <= ctrl_addr_d;
      ctrl_wdata_q  <= ctrl_wdata_d;
      strobe_q      <= strobe_d;
      bresp_q       <= bresp_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cms_ctrl_axil_bridge.sv
`default_nettype none
// Self-checking bench for cms_ctrl_axil_bridge: directed register-map steps
// followed by random traffic scored against a register-level model.
module tb_cms_ctrl_axil_bridge;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable;

  cms_ctrl_axil_bridge_if #(.AXIL_ADDR_WIDTH(6)) bus ();

  cms_ctrl_axil_bridge dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axi             (bus),
    .ctrl_addr         (ctrl_addr),
    .ctrl_wdata        (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CMS_CTRL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int strobes_seen = 0;
  int m_strobes = 0;

  // Register-level reference model
  logic [31:0] m_lo, m_hi, m_count;
  logic [7:0]  m_addr;
  logic [63:0] m_wdata;

  always @(negedge clk) if (ctrl_write_enable) strobes_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lo = 0; m_hi = 0; m_count = 0; m_addr = 0; m_wdata = 0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic stb);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    resp = 2'b00;
    stb  = 1'b0;
    if (a >= 6'h10 || a >= 6'h0C) resp = 2'b10;
    else if (a < 6'h04) m_lo = (m_lo & ~mask) | (d & mask);
    else if (a < 6'h08) m_hi = (m_hi & ~mask) | (d & mask);
    else if (s[0]) begin
      if (ADDR_CHECK && d[7:0] > 8'd22) resp = 2'b10;
      else begin
        m_addr  = d[7:0];
        m_wdata = {m_hi, m_lo};
        m_count = m_count + 1;
        m_strobes++;
        stb = 1'b1;
      end
    end
  endtask

  task automatic model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    if (a >= 6'h10)      begin d = 0; resp = 2'b10; end
    else if (a < 6'h04)  d = m_lo;
    else if (a < 6'h08)  d = m_hi;
    else if (a < 6'h0C)  d = {24'd0, m_addr};
    else                 d = m_count;
  endtask

  task automatic idle_bus();
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic stb,
                           output logic [7:0] ca, output logic [63:0] cd);
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1; bus.wvalid = 1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); #1; n++; end
    chk("aw_accept_in_time", n < 20, 1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    #1;
    chk("bvalid_after_accept", bus.bvalid, 1);
    resp = bus.bresp; stb = ctrl_write_enable; ca = ctrl_addr; cd = ctrl_wdata;
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    #1;
    chk("strobe_single_cycle", {bus.bvalid, ctrl_write_enable}, 2'b00);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0]  resp, eresp;
    logic        stb, estb;
    logic [7:0]  ca;
    logic [63:0] cd;
    model_write(a, d, s, eresp, estb);
    axi_write(a, d, s, resp, stb, ca, cd);
    chk("bresp", resp, eresp);
    chk("strobe", stb, estb);
    chk("ctrl_addr", ca, m_addr);
    chk("ctrl_wdata", cd, m_wdata);
  endtask

  task automatic do_read(input logic [5:0] a);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    model_read(a, ed, er);
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ar_accept_in_time", n < 20, 1);
    @(negedge clk);
    bus.arvalid = 0;
    #1;
    chk("rvalid", bus.rvalid, 1);
    chk("rdata", bus.rdata, ed);
    chk("rresp", bus.rresp, er);
    bus.rready = 1;
    @(negedge clk);
    bus.rready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  er;
    logic        es;
    logic [31:0] ed;
    logic [31:0] pre_count;

    idle_bus();
    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                          ctrl_write_enable}, 6'd0);
    chk("reset_ctrl", {ctrl_addr, ctrl_wdata[55:0]}, 64'd0);
    rst_n = 1;
    for (int a = 0; a < 16; a += 4) do_read(6'(a));

    // Basic issue sequence
    do_write(6'h00, 32'hDEADBEEF, 4'hF);
    do_write(6'h04, 32'h01234567, 4'hF);
    do_write(6'h08, 32'h00000015, 4'h1);
    chk("issue_addr", ctrl_addr, 8'h15);
    chk("issue_data", ctrl_wdata, 64'h01234567DEADBEEF);
    do_read(6'h0C);

    // AW arrives 5 cycles before W; no accept until both are valid
    @(negedge clk);
    bus.awaddr = 6'h04; bus.wdata = 32'h13572468; bus.wstrb = 4'hF; bus.awvalid = 1;
    for (int i = 0; i < 5; i++) begin
      #1; chk("no_accept_aw_only", {bus.awready, bus.wready}, 2'b00);
      @(negedge clk);
    end
    bus.wvalid = 1;
    #1;
    chk("accept_both_valid", {bus.awready, bus.wready}, 2'b11);
    model_write(6'h04, 32'h13572468, 4'hF, er, es);
    @(negedge clk);
    // Second write held pending while B is stalled
    bus.awaddr = 6'h00; bus.wdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1; chk("stall_no_accept", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
      @(negedge clk);
    end
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    #1;
    chk("accept_after_b", {bus.awready, bus.wready}, 2'b11);
    model_write(6'h00, 32'h11111111, 4'hF, er, es);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    #1;
    chk("second_bresp", {bus.bvalid, bus.bresp}, {1'b1, er});
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    do_read(6'h04);
    do_read(6'h00);

    // Partial byte strobe
    do_write(6'h00, 32'h00000000, 4'hF);
    do_write(6'h00, 32'hAABBCCDD, 4'b0010);
    chk("strobe_merge_model", m_lo, 32'h0000CC00);
    do_read(6'h00);
    do_write(6'h04, 32'hFFFFFFFF, 4'h0);
    do_read(6'h04);

    // Address range, unmapped and read-only targets
    do_write(6'h08, 32'h00000040, 4'h1);
    do_write(6'h08, 32'h00000016, 4'h1);
    do_write(6'h08, 32'h00000009, 4'h0);
    do_read(6'h0C);
    do_read(6'h20);
    do_write(6'h0C, 32'h12345678, 4'hF);
    do_write(6'h30, 32'h12345678, 4'hF);
    do_read(6'h0C);

    // Same-cycle read and write of DATA_LO: read sees the old value
    model_read(6'h00, ed, er);
    @(negedge clk);
    bus.awaddr = 6'h00; bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.araddr = 6'h00; bus.arvalid = 1;
    @(negedge clk);
    idle_bus();
    #1;
    chk("rw_same_rdata", {bus.rvalid, bus.rdata}, {1'b1, ed});
    model_write(6'h00, 32'h55AA55AA, 4'hF, er, es);
    chk("rw_same_bresp", {bus.bvalid, bus.bresp}, {1'b1, er});
    bus.bready = 1; bus.rready = 1;
    @(negedge clk);
    idle_bus();
    do_read(6'h00);

    // ISSUE_COUNT read landing on the strobe cycle
    pre_count = m_count;
    model_write(6'h08, 32'h00000007, 4'h1, er, es);
    @(negedge clk);
    bus.awaddr = 6'h08; bus.wdata = 32'h00000007; bus.wstrb = 4'h1;
    bus.awvalid = 1; bus.wvalid = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0; bus.araddr = 6'h0C; bus.arvalid = 1;
    #1;
    chk("strobe_cycle_read", {ctrl_write_enable, bus.arready}, 2'b11);
    @(negedge clk);
    bus.arvalid = 0;
    #1;
    chk("count_pre_increment", {bus.rvalid, bus.rdata}, {1'b1, pre_count});
    bus.bready = 1; bus.rready = 1;
    @(negedge clk);
    idle_bus();
    do_read(6'h0C);

    // Counter wrap
    @(negedge clk);
    force dut.issue_count_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.issue_count_q;
    m_count = 32'hFFFFFFFF;
    do_read(6'h0C);
    do_write(6'h08, 32'h00000003, 4'h1);
    do_read(6'h0C);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      logic [5:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      case ($urandom_range(0, 4))
        0:       a = 6'h00;
        1:       a = 6'h04;
        2:       a = 6'h08;
        3:       a = 6'($urandom_range(16, 63));
        default: a = 6'($urandom_range(0, 15));
      endcase
      d = $urandom;
      if (a[3:2] == 2'd2) d[7:0] = 8'($urandom_range(0, 40));
      s = 4'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(a);
      else                           do_write(a, d, s);
    end

    // Reset while the response is pending
    @(negedge clk);
    bus.awaddr = 6'h04; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    #1;
    chk("pre_reset_bvalid", bus.bvalid, 1);
    rst_n = 0;
    #1;
    chk("reset_drops_b", {bus.bvalid, ctrl_write_enable}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    chk("post_reset_ctrl", {ctrl_addr, ctrl_wdata[55:0]}, 64'd0);
    do_read(6'h04);
    do_read(6'h0C);

    repeat (2) @(negedge clk);
    chk("strobe_total", strobes_seen, m_strobes);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
